// File: rtl/mem_burst_arb.sv
// Two-requester round-robin arbiter sharing one burst memory controller.
// Per-requester strobes are gated copies of the controller strobes; len/addr are latched at grant.
module mem_burst_arb #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 32
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,

    input  logic                     m0_rd_burst_req,
    input  logic                     m0_wr_burst_req,
    input  logic [9:0]               m0_rd_burst_len,
    input  logic [9:0]               m0_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     m0_rd_burst_addr,
    input  logic [ADDR_BITS-1:0]     m0_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] m0_wr_burst_data,
    output logic                     m0_wr_burst_data_req,
    output logic                     m0_rd_burst_data_valid,
    output logic                     m0_rd_burst_finish,
    output logic                     m0_wr_burst_finish,
    output logic [MEM_DATA_BITS-1:0] m0_rd_burst_data,

    input  logic                     m1_rd_burst_req,
    input  logic                     m1_wr_burst_req,
    input  logic [9:0]               m1_rd_burst_len,
    input  logic [9:0]               m1_wr_burst_len,
    input  logic [ADDR_BITS-1:0]     m1_rd_burst_addr,
    input  logic [ADDR_BITS-1:0]     m1_wr_burst_addr,
    input  logic [MEM_DATA_BITS-1:0] m1_wr_burst_data,
    output logic                     m1_wr_burst_data_req,
    output logic                     m1_rd_burst_data_valid,
    output logic                     m1_rd_burst_finish,
    output logic                     m1_wr_burst_finish,
    output logic [MEM_DATA_BITS-1:0] m1_rd_burst_data,

    output logic                     rd_burst_req,
    output logic                     wr_burst_req,
    output logic [9:0]               rd_burst_len,
    output logic [9:0]               wr_burst_len,
    output logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0] wr_burst_data,
    input  logic                     rd_burst_data_valid,
    input  logic                     wr_burst_data_req,
    input  logic                     rd_burst_finish,
    input  logic                     wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0] rd_burst_data,

    output logic                     busy,
    output logic                     grant_id
);

    // state | meaning
    // IDLE  | no request pending        ARB  | pick requester and burst type
    // WR/RD | controller owns the burst HOLD | one settle cycle while finisher drops req
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_WR, S_RD, S_HOLD} state_t;

    state_t                 state_q;
    logic                   grant_q;
    logic                   last_q;
    logic                   rd_req_q;
    logic                   wr_req_q;
    logic [9:0]             rd_len_q;
    logic [9:0]             wr_len_q;
    logic [ADDR_BITS-1:0]   rd_addr_q;
    logic [ADDR_BITS-1:0]   wr_addr_q;
    logic                   zl_fin_q;
    logic                   zl_wr_q;

    logic                   req0;
    logic                   req1;
    logic                   any_req;
    logic                   arb_gnt_d;
    logic                   arb_wr_d;
    logic [9:0]             arb_len_d;
    logic [ADDR_BITS-1:0]   arb_addr_d;
    logic                   in_wr;
    logic                   in_rd;

    assign req0    = m0_rd_burst_req | m0_wr_burst_req;
    assign req1    = m1_rd_burst_req | m1_wr_burst_req;
    assign any_req = req0 | req1;

    always_comb begin
        arb_gnt_d = (req0 & req1) ? ~last_q : req1;
        arb_wr_d  = arb_gnt_d ? m1_wr_burst_req : m0_wr_burst_req;
        if (arb_gnt_d) begin
            arb_len_d  = arb_wr_d ? m1_wr_burst_len  : m1_rd_burst_len;
            arb_addr_d = arb_wr_d ? m1_wr_burst_addr : m1_rd_burst_addr;
        end else begin
            arb_len_d  = arb_wr_d ? m0_wr_burst_len  : m0_rd_burst_len;
            arb_addr_d = arb_wr_d ? m0_wr_burst_addr : m0_rd_burst_addr;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_len_q  <= '0;
            wr_len_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            zl_fin_q  <= 1'b0;
            zl_wr_q   <= 1'b0;
        end else begin
            zl_fin_q <= 1'b0;
            case (state_q)
                S_IDLE: if (any_req) state_q <= S_ARB;
                S_ARB: begin
                    if (!any_req) begin
                        state_q <= S_IDLE;
                    end else begin
                        grant_q <= arb_gnt_d;
                        last_q  <= arb_gnt_d;
                        if (arb_len_d == 10'd0) begin
                            // empty burst: finish is generated here, controller never sees it
                            zl_fin_q <= 1'b1;
                            zl_wr_q  <= arb_wr_d;
                            state_q  <= S_HOLD;
                        end else if (arb_wr_d) begin
                            wr_len_q  <= arb_len_d;
                            wr_addr_q <= arb_addr_d;
                            wr_req_q  <= 1'b1;
                            state_q   <= S_WR;
                        end else begin
                            rd_len_q  <= arb_len_d;
                            rd_addr_q <= arb_addr_d;
                            rd_req_q  <= 1'b1;
                            state_q   <= S_RD;
                        end
                    end
                end
                S_WR: if (wr_burst_finish) begin
                    wr_req_q <= 1'b0;
                    state_q  <= S_HOLD;
                end
                S_RD: if (rd_burst_finish) begin
                    rd_req_q <= 1'b0;
                    state_q  <= S_HOLD;
                end
                S_HOLD: state_q <= any_req ? S_ARB : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_wr = (state_q == S_WR);
    assign in_rd = (state_q == S_RD);

    assign m0_wr_burst_data_req   = in_wr & ~grant_q & wr_burst_data_req;
    assign m1_wr_burst_data_req   = in_wr &  grant_q & wr_burst_data_req;
    assign m0_rd_burst_data_valid = in_rd & ~grant_q & rd_burst_data_valid;
    assign m1_rd_burst_data_valid = in_rd &  grant_q & rd_burst_data_valid;
    assign m0_wr_burst_finish = (in_wr & ~grant_q & wr_burst_finish) | (zl_fin_q &  zl_wr_q & ~grant_q);
    assign m1_wr_burst_finish = (in_wr &  grant_q & wr_burst_finish) | (zl_fin_q &  zl_wr_q &  grant_q);
    assign m0_rd_burst_finish = (in_rd & ~grant_q & rd_burst_finish) | (zl_fin_q & ~zl_wr_q & ~grant_q);
    assign m1_rd_burst_finish = (in_rd &  grant_q & rd_burst_finish) | (zl_fin_q & ~zl_wr_q &  grant_q);

    assign m0_rd_burst_data = rd_burst_data;
    assign m1_rd_burst_data = rd_burst_data;
    assign wr_burst_data    = in_wr ? (grant_q ? m1_wr_burst_data : m0_wr_burst_data) : '0;

    assign rd_burst_req  = rd_req_q;
    assign wr_burst_req  = wr_req_q;
    assign rd_burst_len  = rd_len_q;
    assign wr_burst_len  = wr_len_q;
    assign rd_burst_addr = rd_addr_q;
    assign wr_burst_addr = wr_addr_q;
    assign busy          = in_wr | in_rd;
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_mem_burst_arb.sv
// Scoreboard bench for mem_burst_arb: a reference model queues the expected burst order,
// a monitor matches observed bursts and finishes against it while a controller model responds.
module tb_mem_burst_arb;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam logic [DW-1:0] WD0 = 64'h0A0A_5555_0000_1111;
    localparam logic [DW-1:0] WD1 = 64'hB1B1_AAAA_2222_3333;

    typedef struct {
        bit            id;
        bit            wr;
        int            len;
        logic [AW-1:0] addr;
    } exp_t;

    logic mem_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // requester index: 0 m0_wr, 1 m0_rd, 2 m1_wr, 3 m1_rd
    logic [3:0]    req_v = '0;
    logic [9:0]    len_v  [4];
    logic [AW-1:0] addr_v [4];

    logic          m0_wr_burst_data_req, m0_rd_burst_data_valid, m0_rd_burst_finish, m0_wr_burst_finish;
    logic          m1_wr_burst_data_req, m1_rd_burst_data_valid, m1_rd_burst_finish, m1_wr_burst_finish;
    logic [DW-1:0] m0_rd_burst_data, m1_rd_burst_data, wr_burst_data;
    logic          rd_burst_req, wr_burst_req, busy, grant_id;
    logic [9:0]    rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic          c_rd_valid = 1'b0, c_wr_dreq = 1'b0, c_rd_fin = 1'b0, c_wr_fin = 1'b0;
    logic [DW-1:0] c_rd_data = '0;

    mem_burst_arb #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .m0_rd_burst_req(req_v[1]), .m0_wr_burst_req(req_v[0]),
        .m0_rd_burst_len(len_v[1]), .m0_wr_burst_len(len_v[0]),
        .m0_rd_burst_addr(addr_v[1]), .m0_wr_burst_addr(addr_v[0]),
        .m0_wr_burst_data(WD0),
        .m0_wr_burst_data_req(m0_wr_burst_data_req), .m0_rd_burst_data_valid(m0_rd_burst_data_valid),
        .m0_rd_burst_finish(m0_rd_burst_finish), .m0_wr_burst_finish(m0_wr_burst_finish),
        .m0_rd_burst_data(m0_rd_burst_data),
        .m1_rd_burst_req(req_v[3]), .m1_wr_burst_req(req_v[2]),
        .m1_rd_burst_len(len_v[3]), .m1_wr_burst_len(len_v[2]),
        .m1_rd_burst_addr(addr_v[3]), .m1_wr_burst_addr(addr_v[2]),
        .m1_wr_burst_data(WD1),
        .m1_wr_burst_data_req(m1_wr_burst_data_req), .m1_rd_burst_data_valid(m1_rd_burst_data_valid),
        .m1_rd_burst_finish(m1_rd_burst_finish), .m1_wr_burst_finish(m1_wr_burst_finish),
        .m1_rd_burst_data(m1_rd_burst_data),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data(wr_burst_data),
        .rd_burst_data_valid(c_rd_valid), .wr_burst_data_req(c_wr_dreq),
        .rd_burst_finish(c_rd_fin), .wr_burst_finish(c_wr_fin),
        .rd_burst_data(c_rd_data),
        .busy(busy), .grant_id(grant_id)
    );

    logic [1:0] o_wdr, o_rdv, o_wf, o_rf;
    assign o_wdr = {m1_wr_burst_data_req, m0_wr_burst_data_req};
    assign o_rdv = {m1_rd_burst_data_valid, m0_rd_burst_data_valid};
    assign o_wf  = {m1_wr_burst_finish, m0_wr_burst_finish};
    assign o_rf  = {m1_rd_burst_finish, m0_rd_burst_finish};

    int   n_chk = 0, n_pass = 0;
    int   cyc = 0;
    exp_t q[$];
    bit   m_last = 1'b1;
    bit   active = 1'b0;
    exp_t act;
    int   cnt = 0;
    int   viol = 0;
    bit   first_ev = 1'b0;
    int   t_issue = 0;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint actual, input longint required);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cyc);
    endtask

    task automatic end_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    // controller model: random beat gaps, occasional strobes of the wrong kind or while idle
    initial begin : controller
        int  ph, rem, idx;
        bit  cw;
        logic [AW-1:0] base;
        ph = 0; rem = 0; idx = 0; cw = 1'b0; base = '0;
        forever begin
            @(posedge mem_clk);
            #1;
            c_wr_dreq = 1'b0; c_rd_valid = 1'b0; c_wr_fin = 1'b0; c_rd_fin = 1'b0;
            c_rd_data = {$urandom, $urandom};
            if (!rst_n) begin ph = 0; continue; end
            case (ph)
                0: if (wr_burst_req || rd_burst_req) begin
                    ph = 1; cw = wr_burst_req; idx = 0;
                    rem  = cw ? int'(wr_burst_len) : int'(rd_burst_len);
                    base = cw ? wr_burst_addr : rd_burst_addr;
                end else if ($urandom_range(7) == 0) begin
                    case ($urandom_range(3))
                        0: c_wr_dreq = 1'b1;
                        1: c_rd_valid = 1'b1;
                        2: c_wr_fin = 1'b1;
                        default: c_rd_fin = 1'b1;
                    endcase
                end
                1: if (!(cw ? wr_burst_req : rd_burst_req)) begin
                    ph = 0;
                end else if (rem == 0) begin
                    if (cw) c_wr_fin = 1'b1; else c_rd_fin = 1'b1;
                    ph = 2;
                end else if ($urandom_range(3) != 0) begin
                    if (cw) c_wr_dreq = 1'b1;
                    else begin c_rd_valid = 1'b1; c_rd_data = DW'(base) + DW'(idx); end
                    idx++; rem--;
                end else if ($urandom_range(1) == 0) begin
                    if (cw) begin c_rd_valid = 1'b1; c_rd_fin = 1'($urandom_range(1)); end
                    else begin c_wr_dreq = 1'b1; c_wr_fin = 1'($urandom_range(1)); end
                end
                default: if (!wr_burst_req && !rd_burst_req) ph = 0;
            endcase
        end
    end

    // requesters drop a request the cycle after its finish is seen
    initial begin : requesters
        logic [3:0] f;
        forever begin
            @(negedge mem_clk);
            f = {o_rf[1], o_wf[1], o_rf[0], o_wf[0]};
            @(posedge mem_clk);
            #1;
            if (f != 4'b0) req_v = req_v & ~f;
        end
    end

    initial begin : monitor
        bit   prev_wr, prev_rd, fsig;
        exp_t e;
        logic [DW-1:0] exp_rd;
        prev_wr = 1'b0; prev_rd = 1'b0;
        forever begin
            @(negedge mem_clk);
            if (!rst_n) begin active = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0; continue; end
            if ((wr_burst_req && !prev_wr) || (rd_burst_req && !prev_rd)) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_burst", longint'(wr_burst_req), 0);
                end else begin
                    e = q.pop_front();
                    chk(wr_burst_req == e.wr && rd_burst_req == !e.wr, "burst_type",
                        longint'({wr_burst_req, rd_burst_req}), longint'({e.wr, !e.wr}));
                    chk(grant_id == e.id, "grant_id", longint'(grant_id), longint'(e.id));
                    chk((e.wr ? int'(wr_burst_len) : int'(rd_burst_len)) == e.len, "burst_len",
                        longint'(e.wr ? wr_burst_len : rd_burst_len), longint'(e.len));
                    chk((e.wr ? wr_burst_addr : rd_burst_addr) == e.addr, "burst_addr",
                        longint'(e.wr ? wr_burst_addr : rd_burst_addr), longint'(e.addr));
                    if (first_ev) chk(cyc - t_issue == 2, "grant_latency", longint'(cyc - t_issue), 2);
                    first_ev = 1'b0;
                    active = 1'b1; act = e; cnt = 0;
                end
            end
            prev_wr = wr_burst_req; prev_rd = rd_burst_req;
            if (busy !== active) viol++;
            if (!(active && act.wr) && wr_burst_data !== '0) viol++;
            for (int x = 0; x < 2; x++) begin
                if (o_wdr[x]) begin
                    if (active && act.wr && act.id == x) begin
                        cnt++;
                        if (wr_burst_data !== (x == 1 ? WD1 : WD0)) viol++;
                    end else viol++;
                end
                if (o_rdv[x]) begin
                    if (active && !act.wr && act.id == x) begin
                        exp_rd = DW'(act.addr) + DW'(cnt);
                        if (m0_rd_burst_data !== exp_rd || m1_rd_burst_data !== exp_rd) viol++;
                        cnt++;
                    end else viol++;
                end
            end
            for (int x = 0; x < 2; x++) begin
                for (int w = 0; w < 2; w++) begin
                    fsig = (w == 1) ? o_wf[x] : o_rf[x];
                    if (!fsig) continue;
                    if (active) begin
                        chk(act.id == x && act.wr == w, "finish_owner", longint'(x * 2 + w),
                            longint'(int'(act.id) * 2 + int'(act.wr)));
                        chk(cnt == act.len, "beat_count", longint'(cnt), longint'(act.len));
                        active = 1'b0;
                    end else if (q.size() == 0) begin
                        chk(1'b0, "unexpected_finish", longint'(x * 2 + w), 0);
                    end else begin
                        e = q.pop_front();
                        chk(e.len == 0 && e.id == x && e.wr == w, "zero_len_finish",
                            longint'(x * 2 + w), longint'(int'(e.id) * 2 + int'(e.wr)));
                        if (first_ev) chk(cyc - t_issue == 2, "zero_len_latency", longint'(cyc - t_issue), 2);
                        first_ev = 1'b0;
                    end
                end
            end
        end
    end

    // reference model: requests held until served; round-robin between requesters, write first
    task automatic start_round(input logic [3:0] bits);
        logic [3:0] pend;
        bit   r0, r1, g, w;
        int   idx;
        exp_t e;
        pend = bits;
        while (pend != 4'b0) begin
            r0 = pend[0] | pend[1];
            r1 = pend[2] | pend[3];
            g  = (r0 && r1) ? !m_last : r1;
            w  = g ? pend[2] : pend[0];
            idx = (g ? 2 : 0) + (w ? 0 : 1);
            e.id = g; e.wr = w; e.len = int'(len_v[idx]); e.addr = addr_v[idx];
            q.push_back(e);
            pend[idx] = 1'b0;
            m_last = g;
        end
        repeat (3) @(posedge mem_clk);
        #1;
        req_v = bits; t_issue = cyc; first_ev = 1'b1;
    endtask

    task automatic wait_round(input int drop_at);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge mem_clk);
            if (drop_at > 0 && active && cnt >= drop_at) req_v = '0;
            if (q.size() == 0 && !active && req_v == 4'b0 && !busy) done = 1'b1;
        end
        if (!done) begin
            chk(1'b0, "round_timeout", longint'(q.size()), 0);
            end_run();
        end
        repeat (3) @(posedge mem_clk);
        chk(viol == 0, "round_violations", longint'(viol), 0);
        viol = 0;
    endtask

    task automatic set_burst(input int idx, input int len, input logic [AW-1:0] addr);
        len_v[idx]  = 10'(len);
        addr_v[idx] = addr;
    endtask

    initial begin : watchdog
        #800000;
        chk(1'b0, "global_timeout", longint'(cyc), 0);
        end_run();
    end

    initial begin : stimulus
        bit ok;
        for (int i = 0; i < 4; i++) set_burst(i, 4, AW'(32'h100 * (i + 1)));
        #2;
        chk(wr_burst_req == 1'b0 && rd_burst_req == 1'b0, "reset_req", longint'({wr_burst_req, rd_burst_req}), 0);
        chk(busy == 1'b0, "reset_busy", longint'(busy), 0);
        chk(grant_id == 1'b0, "reset_grant", longint'(grant_id), 0);
        chk(wr_burst_len == 10'd0 && rd_burst_len == 10'd0, "reset_len", longint'({wr_burst_len, rd_burst_len}), 0);
        chk(wr_burst_addr == '0 && rd_burst_addr == '0, "reset_addr", longint'(wr_burst_addr | rd_burst_addr), 0);
        chk({o_wf, o_rf, o_wdr, o_rdv} == 8'b0, "reset_strobes", longint'({o_wf, o_rf, o_wdr, o_rdv}), 0);
        repeat (3) @(negedge mem_clk);
        rst_n = 1'b1;

        set_burst(1, 6, 32'h0000_4000); set_burst(3, 5, 32'h0000_8000);
        for (int r = 0; r < 3; r++) begin start_round(4'b1010); wait_round(0); end

        set_burst(0, 128, 32'h0200_0000);
        start_round(4'b0001); wait_round(0);

        set_burst(2, 7, 32'h0000_C000); set_burst(3, 9, 32'h0000_D000);
        start_round(4'b1100); wait_round(0);

        set_burst(1, 0, 32'h0000_0040);
        start_round(4'b0010); wait_round(0);

        set_burst(3, 20, 32'h0001_0000);
        start_round(4'b1000); wait_round(5);

        set_burst(0, 128, 32'h0200_0000);
        start_round(4'b0001);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge mem_clk);
            if (active && act.wr && cnt >= 40) ok = 1'b1;
        end
        chk(ok, "reach_beat_40", longint'(cnt), 40);
        @(posedge mem_clk);
        #2;
        rst_n = 1'b0; req_v = '0;
        #1;
        chk(wr_burst_req == 1'b0, "rst_mid_wr_req", longint'(wr_burst_req), 0);
        chk(busy == 1'b0, "rst_mid_busy", longint'(busy), 0);
        chk(o_wf == 2'b00, "rst_mid_finish", longint'(o_wf), 0);
        q.delete();
        m_last = 1'b1;
        repeat (2) @(negedge mem_clk);
        rst_n = 1'b1;
        repeat (20) @(posedge mem_clk);
        chk(viol == 0, "post_reset_violations", longint'(viol), 0);
        viol = 0;

        set_burst(0, 3, 32'h0000_0300); set_burst(2, 3, 32'h0000_0700);
        start_round(4'b0101); wait_round(0);

        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 4; i++)
                set_burst(i, ($urandom_range(4) == 0) ? 0 : int'($urandom_range(12, 1)), AW'($urandom));
            start_round(4'($urandom_range(15, 1)));
            wait_round(0);
        end
        end_run();
    end
endmodule
